mc_controller: RTL and testbench

//  Multicycle control FSM for the 16-bit accumulator MIPS: consumes datapath.instruction and zero, drives every datapath select/enable.
//  R0 is the accumulator; instruction = {opcode[15:12], Ri[11:9], field[8:0]}, adr12 = inst[11:0].

---
 rtl/mc_pkg.sv | 85 ++++++++
 rtl/mc_alu_ctrl.sv | 39 +++
 rtl/mc_controller.sv | 155 +++++++++++++++
 tb/tb_mc_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the accumulator MIPS multicycle controller and datapath ALU.
// Holds opcode/func codes, mux select encodings, the controller state enum and decode helpers.
package mc_pkg;

  localparam int INST_W = 16;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD  = 4'b0000,
    OP_STORE = 4'b0001,
    OP_JUMP  = 4'b0010,
    OP_BRZ   = 4'b0100,
    OP_TYPEC = 4'b1000,
    OP_ADDI  = 4'b1100,
    OP_SUBI  = 4'b1101,
    OP_ANDI  = 4'b1110,
    OP_ORI   = 4'b1111
  } opcode_e;

  localparam logic [8:0] FN_MOVETO   = 9'b0_0000_0001;
  localparam logic [8:0] FN_MOVEFROM = 9'b0_0000_0010;
  localparam logic [8:0] FN_ADD      = 9'b0_0000_0100;
  localparam logic [8:0] FN_SUB      = 9'b0_0000_1000;
  localparam logic [8:0] FN_AND      = 9'b0_0001_0000;
  localparam logic [8:0] FN_OR       = 9'b0_0010_0000;
  localparam logic [8:0] FN_NOT      = 9'b0_0100_0000;
  localparam logic [8:0] FN_NOP      = 9'b0_1000_0000;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_AND    = 3'b010,
    ALU_OR     = 3'b011,
    ALU_NOT_B  = 3'b100,
    ALU_PASS_B = 3'b101,
    ALU_PASS_A = 3'b110
  } aluop_e;

  typedef enum logic [1:0] {
    PC_ADR12  = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_PAGE   = 2'd2,
    PC_ALURES = 2'd3
  } pcsrc_e;

  typedef enum logic [1:0] {
    WS_A      = 2'd0,
    WS_ALUOUT = 2'd1,
    WS_MDR    = 2'd2
  } writesrc_e;

  typedef enum logic [1:0] {
    SB_B     = 2'd0,
    SB_ONE   = 2'd1,
    SB_IMM12 = 2'd2
  } alusrcb_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_LD_MEM,
    S_LD_WB,
    S_ST_MEM,
    S_RT_EX,
    S_IM_EX,
    S_ALU_WB
  } state_e;

  function automatic logic isValidOp(input logic [OP_W-1:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_JUMP, OP_BRZ, OP_TYPEC,
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: isValidOp = 1'b1;
      default:                           isValidOp = 1'b0;
    endcase
  endfunction

  function automatic logic isValidFunc(input logic [8:0] fn);
    case (fn)
      FN_MOVETO, FN_MOVEFROM, FN_ADD, FN_SUB,
      FN_AND, FN_OR, FN_NOT, FN_NOP: isValidFunc = 1'b1;
      default:                       isValidFunc = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_ctrl.sv
// ALU operation select and illegal-instruction detection for the multicycle controller.
// Purely combinational from the current state, opcode and TYPE-C function field.
module mc_alu_ctrl
  import mc_pkg::*;
(
  input  state_e          state_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic [8:0]      func_i,
  output logic [2:0]      aluOp_o,
  output logic            illegal_o
);

  always_comb begin
    aluOp_o   = ALU_ADD;
    illegal_o = 1'b0;
    case (state_i)
      S_DECODE: begin
        if (opcode_i == OP_BRZ) aluOp_o = ALU_PASS_A;
        illegal_o = !isValidOp(opcode_i) ||
                    ((opcode_i == OP_TYPEC) && !isValidFunc(func_i));
      end
      S_RT_EX: begin
        case (func_i)
          FN_MOVEFROM: aluOp_o = ALU_PASS_B;
          FN_ADD:      aluOp_o = ALU_ADD;
          FN_SUB:      aluOp_o = ALU_SUB;
          FN_AND:      aluOp_o = ALU_AND;
          FN_OR:       aluOp_o = ALU_OR;
          FN_NOT:      aluOp_o = ALU_NOT_B;
          default:     aluOp_o = ALU_ADD;
        endcase
      end
      // ADDI..ORI share opcode[3:2]=11, so the low bits map straight onto ADD/SUB/AND/OR
      S_IM_EX: aluOp_o = {1'b0, opcode_i[1:0]};
      default: aluOp_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the 16-bit accumulator MIPS; drives every datapath select and enable.
// While rst is high all outputs are forced to zero regardless of the held state.
module mc_controller
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] instruction,
  input  logic              zero,
  output logic [1:0]        PCSrc,
  output logic              PCWrite,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Reg1Src,
  output logic              RegDst,
  output logic [1:0]        writeSrc,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [2:0]        ALUop,
  output logic              IRWrite,
  output logic              instr_done,
  output logic              illegal
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] opcode;
  logic [8:0]      func;
  logic [2:0]      aluOpCtrl;
  logic            illegalCtrl;
  logic            unusedRi;

  assign opcode   = instruction[15:12];
  assign func     = instruction[8:0];
  assign unusedRi = ^instruction[11:9];

  mc_alu_ctrl uAluCtrl (
    .state_i   (state_q),
    .opcode_i  (opcode),
    .func_i    (func),
    .aluOp_o   (aluOpCtrl),
    .illegal_o (illegalCtrl)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (illegalCtrl) state_d = S_FETCH;
        else begin
          case (opcode)
            OP_LOAD:                          state_d = S_LD_MEM;
            OP_STORE:                         state_d = S_ST_MEM;
            OP_TYPEC:                         state_d = S_RT_EX;
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: state_d = S_IM_EX;
            default:                          state_d = S_FETCH;
          endcase
        end
      end
      S_LD_MEM: state_d = S_LD_WB;
      S_RT_EX:  state_d = ((func == FN_MOVETO) || (func == FN_NOP)) ? S_FETCH : S_ALU_WB;
      S_IM_EX:  state_d = S_ALU_WB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCSrc      = PC_ADR12;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Reg1Src    = 1'b0;
    RegDst     = 1'b0;
    writeSrc   = WS_A;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SB_B;
    ALUop      = ALU_ADD;
    IRWrite    = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      ALUop   = aluOpCtrl;
      illegal = illegalCtrl;
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          ALUSrcB = SB_ONE;
          PCSrc   = PC_ALURES;
          PCWrite = 1'b1;
        end
        S_DECODE: begin
          if (illegalCtrl) instr_done = 1'b1;
          else if (opcode == OP_JUMP) begin
            PCSrc      = PC_ADR12;
            PCWrite    = 1'b1;
            instr_done = 1'b1;
          end else if (opcode == OP_BRZ) begin
            ALUSrcA    = 1'b1;
            PCSrc      = PC_PAGE;
            PCWrite    = zero;
            instr_done = 1'b1;
          end
        end
        S_LD_MEM: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_LD_WB: begin
          RegWrite   = 1'b1;
          writeSrc   = WS_MDR;
          instr_done = 1'b1;
        end
        S_ST_MEM: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_RT_EX: begin
          if (func == FN_MOVETO) begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            writeSrc   = WS_A;
            instr_done = 1'b1;
          end else if (func == FN_NOP) begin
            instr_done = 1'b1;
          end else begin
            ALUSrcA = 1'b1;
            ALUSrcB = SB_B;
          end
        end
        S_IM_EX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SB_IMM12;
        end
        S_ALU_WB: begin
          RegWrite   = 1'b1;
          writeSrc   = WS_ALUOUT;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed and random instruction streams checked cycle by cycle
// against a per-instruction reference of the expected control outputs.
module tb_mc_controller;

  typedef struct packed {
    logic [1:0] pcSrc;
    logic       pcWrite;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       reg1Src;
    logic       regDst;
    logic [1:0] writeSrc;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic       irWrite;
    logic       done;
    logic       illegal;
  } ctrl_t;

  logic        clk;
  logic        rst;
  logic [15:0] instruction;
  logic        zero;
  logic [1:0]  PCSrc;
  logic        PCWrite, IorD, MemRead, MemWrite, Reg1Src, RegDst;
  logic [1:0]  writeSrc;
  logic        RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUop;
  logic        IRWrite, instr_done, illegal;
  ctrl_t       obs;

  int checkCount = 0;
  int errorCount = 0;

  mc_controller dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .zero        (zero),
    .PCSrc       (PCSrc),
    .PCWrite     (PCWrite),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Reg1Src     (Reg1Src),
    .RegDst      (RegDst),
    .writeSrc    (writeSrc),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUop       (ALUop),
    .IRWrite     (IRWrite),
    .instr_done  (instr_done),
    .illegal     (illegal)
  );

  assign obs = {PCSrc, PCWrite, IorD, MemRead, MemWrite, Reg1Src, RegDst, writeSrc,
                RegWrite, ALUSrcA, ALUSrcB, ALUop, IRWrite, instr_done, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [19:0] observed, input logic [19:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: an instruction is classified from its opcode/func and mapped to its cycle list
  function automatic logic isIllegal(input logic [15:0] instr);
    logic [3:0] op;
    logic [8:0] f;
    logic       legalOp, legalFunc;
    op        = instr[15:12];
    f         = instr[8:0];
    legalOp   = op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd12, 4'd13, 4'd14, 4'd15};
    legalFunc = ($countones(f) == 1) && !f[8];
    return !legalOp || ((op == 4'd8) && !legalFunc);
  endfunction

  function automatic int instLength(input logic [15:0] instr);
    logic [3:0] op;
    logic [8:0] f;
    op = instr[15:12];
    f  = instr[8:0];
    if (isIllegal(instr) || op == 4'd2 || op == 4'd4) return 2;
    if (op == 4'd1) return 3;
    if (op == 4'd8 && (f == 9'd1 || f == 9'd128)) return 3;
    return 4;
  endfunction

  function automatic logic [2:0] funcAluOp(input logic [8:0] f);
    int idx;
    idx = 0;
    for (int i = 0; i < 9; i++) if (f[i]) idx = i;
    if (idx == 1) return 3'd5;
    if (idx == 6) return 3'd4;
    return 3'(idx - 2);
  endfunction

  function automatic ctrl_t expectedCtrl(input logic [15:0] instr, input logic z, input int cyc);
    ctrl_t      e;
    logic [3:0] op;
    logic [8:0] f;
    e  = '0;
    op = instr[15:12];
    f  = instr[8:0];
    if (cyc == 0) begin
      e.memRead = 1'b1;
      e.irWrite = 1'b1;
      e.aluSrcB = 2'd1;
      e.pcSrc   = 2'd3;
      e.pcWrite = 1'b1;
      return e;
    end
    e.done = (cyc == instLength(instr) - 1);
    if (cyc == 1) begin
      if (isIllegal(instr)) e.illegal = 1'b1;
      else if (op == 4'd2) e.pcWrite = 1'b1;
      else if (op == 4'd4) begin
        e.aluSrcA = 1'b1;
        e.aluOp   = 3'd6;
        e.pcSrc   = 2'd2;
        e.pcWrite = z;
      end
    end else if (cyc == 2) begin
      if (op == 4'd0) begin
        e.iorD    = 1'b1;
        e.memRead = 1'b1;
      end else if (op == 4'd1) begin
        e.iorD     = 1'b1;
        e.memWrite = 1'b1;
      end else if (op == 4'd8) begin
        if (f == 9'd1) begin
          e.regWrite = 1'b1;
          e.regDst   = 1'b1;
        end else if (f != 9'd128) begin
          e.aluSrcA = 1'b1;
          e.aluOp   = funcAluOp(f);
        end
      end else begin
        e.aluSrcA = 1'b1;
        e.aluSrcB = 2'd2;
        e.aluOp   = 3'(op - 4'd12);
      end
    end else if (cyc == 3) begin
      e.regWrite = 1'b1;
      e.writeSrc = (op == 4'd0) ? 2'd2 : 2'd1;
    end
    return e;
  endfunction

  // Entered just after a negedge with the DUT in FETCH; leaves just after the negedge of the next FETCH
  task automatic applyStimulus(input logic [15:0] instr, input int zeroMode);
    int    len;
    ctrl_t exp;
    len = instLength(instr);
    for (int cyc = 0; cyc < len; cyc++) begin
      instruction = (cyc == 0) ? 16'($urandom) : instr;
      zero        = (zeroMode == 2) ? 1'($urandom) : 1'(zeroMode);
      #1;
      exp = expectedCtrl(instr, zero, cyc);
      checkOutput($sformatf("inst %h cycle %0d", instr, cyc), obs, exp);
      checkOutput($sformatf("exclusive enables %h cycle %0d", instr, cyc),
                  {18'd0, obs.memRead & obs.memWrite, obs.regWrite & obs.pcWrite}, 20'd0);
      @(negedge clk);
    end
  endtask

  function automatic logic [15:0] randomInstr();
    logic [3:0] op;
    logic [8:0] f;
    op = 4'($urandom_range(0, 15));
    if (op == 4'd8 && $urandom_range(0, 3) != 0) f = 9'(1 << $urandom_range(0, 7));
    else f = 9'($urandom);
    return {op, 3'($urandom), f};
  endfunction

  initial begin
    rst         = 1'b1;
    instruction = 16'h0005;
    zero        = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("reset hold %0d", i), obs, 20'd0);
    end
    rst = 1'b0;

    applyStimulus(16'h0123, 2);
    applyStimulus(16'h4055, 1);
    applyStimulus(16'h4055, 0);
    applyStimulus(16'h8604, 2);
    applyStimulus(16'h8601, 2);
    applyStimulus(16'hCFFF, 2);
    applyStimulus(16'h3000, 2);
    applyStimulus(16'h8003, 2);
    applyStimulus(16'h1ABC, 2);
    applyStimulus(16'h2ABC, 2);
    applyStimulus(16'h8680, 2);
    applyStimulus(16'h8440, 2);
    applyStimulus(16'hD002, 2);
    applyStimulus(16'h8000, 2);

    // Abort a LOAD in its memory cycle and confirm the writeback never happens
    instruction = 16'h0123;
    for (int cyc = 0; cyc < 2; cyc++) begin
      #1;
      checkOutput($sformatf("abort load cycle %0d", cyc), obs, expectedCtrl(16'h0123, zero, cyc));
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checkOutput("reset during LD_MEM", obs, 20'd0);
    @(negedge clk);
    #1;
    checkOutput("reset after LD_MEM", obs, 20'd0);
    rst = 1'b0;
    applyStimulus(16'h2000, 2);

    for (int n = 0; n < 400; n++) applyStimulus(randomInstr(), 2);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
